// File: rtl/multi_prescaler_if.sv
// Configuration and tick bus of the multi-channel prescaler.
// master = controller driving configuration; slave = the prescaler itself.
interface multi_prescaler_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 10
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_limit;
    logic              cfg_en;
    logic              cfg_oneshot;
    logic              sync;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] tick_d;
    logic [NUM_CH-1:0] active;

    modport master (
        output cfg_we, cfg_ch, cfg_limit, cfg_en, cfg_oneshot, sync,
        input  tick, tick_d, active
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_limit, cfg_en, cfg_oneshot, sync,
        output tick, tick_d, active
    );
endinterface

// File: rtl/multi_prescaler.sv
// Multi-channel clock-enable generator: each channel ticks once every limit+1
// cycles, with per-channel enable, one-shot mode and a global phase restart.
module multi_prescaler #(
    parameter int NUM_CH        = 4,
    parameter int CNT_W         = 10,
    parameter int DEFAULT_LIMIT = 30
) (
    input  logic               CLK,
    input  logic               RESETn,
    multi_prescaler_if.slave   bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] tick_vec;
    logic [NUM_CH-1:0] en_vec;
    logic [NUM_CH-1:0] tick_d_reg;
    logic              cfg_ok;

    // Channel numbers beyond NUM_CH are representable when NUM_CH is not a power of two.
    assign cfg_ok = (32'(bus.cfg_ch) < 32'(NUM_CH));

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] limit_reg;
            logic             en_reg;
            logic             oneshot_reg;
            logic             tick_reg;
            logic             wr_hit;

            assign wr_hit = bus.cfg_we && cfg_ok && (bus.cfg_ch == CH_W'(gi));

            // Priority: write, then sync, then disable, then normal counting.
            always_ff @(posedge CLK or negedge RESETn) begin
                if (!RESETn) begin
                    cnt_reg     <= '0;
                    limit_reg   <= CNT_W'(DEFAULT_LIMIT);
                    en_reg      <= 1'b1;
                    oneshot_reg <= 1'b0;
                    tick_reg    <= 1'b0;
                end else if (wr_hit) begin
                    limit_reg   <= bus.cfg_limit;
                    en_reg      <= bus.cfg_en;
                    oneshot_reg <= bus.cfg_oneshot;
                    cnt_reg     <= '0;
                    tick_reg    <= 1'b0;
                end else if (bus.sync || !en_reg) begin
                    cnt_reg  <= '0;
                    tick_reg <= 1'b0;
                end else if (cnt_reg >= limit_reg) begin
                    cnt_reg  <= '0;
                    tick_reg <= 1'b1;
                    // One-shot disarms on the edge that produces its tick.
                    if (oneshot_reg) begin
                        en_reg <= 1'b0;
                    end
                end else begin
                    cnt_reg  <= cnt_reg + CNT_W'(1);
                    tick_reg <= 1'b0;
                end
            end

            assign tick_vec[gi] = tick_reg;
            assign en_vec[gi]   = en_reg;
        end
    endgenerate

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            tick_d_reg <= '0;
        end else begin
            tick_d_reg <= tick_vec;
        end
    end

    assign bus.tick   = tick_vec;
    assign bus.tick_d = tick_d_reg;
    assign bus.active = en_vec;
endmodule

// File: tb/tb_multi_prescaler.sv
// Directed bench for multi_prescaler: defaults, reprogramming, limit 0,
// one-shot, sync alignment, out-of-range writes and mid-count reset.
module tb_multi_prescaler;
    logic CLK;
    logic RESETn;
    int   n_checks;
    int   n_fail;

    multi_prescaler_if #(.NUM_CH(4), .CNT_W(10)) bus ();
    multi_prescaler_if #(.NUM_CH(5), .CNT_W(10)) bus2 ();

    multi_prescaler #(.NUM_CH(4), .CNT_W(10), .DEFAULT_LIMIT(30)) u_dut (
        .CLK    (CLK),
        .RESETn (RESETn),
        .bus    (bus.slave)
    );

    // Five channels leave channel codes 5..7 unused, so out-of-range writes are testable.
    multi_prescaler #(.NUM_CH(5), .CNT_W(10), .DEFAULT_LIMIT(30)) u_dut2 (
        .CLK    (CLK),
        .RESETn (RESETn),
        .bus    (bus2.slave)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [9:0] limit,
                             input logic en, input logic os);
        bus.cfg_we      = 1'b1;
        bus.cfg_ch      = ch;
        bus.cfg_limit   = limit;
        bus.cfg_en      = en;
        bus.cfg_oneshot = os;
        step(1);
        bus.cfg_we      = 1'b0;
    endtask

    // Counts ticks of one channel over n cycles and records the first tick cycle.
    task automatic watch(input int n, input int ch, output int cnt, output int first);
        cnt   = 0;
        first = -1;
        for (int i = 1; i <= n; i++) begin
            step(1);
            if (bus.tick[ch]) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
    endtask

    initial begin
        int cnt;
        int first;
        int both;
        int skew;
        int cnt2;
        int first2;

        n_checks = 0;
        n_fail   = 0;
        RESETn   = 1'b0;
        bus.cfg_we = 1'b0;  bus.cfg_ch = '0;  bus.cfg_limit = '0;
        bus.cfg_en = 1'b0;  bus.cfg_oneshot = 1'b0;  bus.sync = 1'b0;
        bus2.cfg_we = 1'b0; bus2.cfg_ch = '0; bus2.cfg_limit = '0;
        bus2.cfg_en = 1'b0; bus2.cfg_oneshot = 1'b0; bus2.sync = 1'b0;

        // Reset values and default period of 31
        step(3);
        check("reset_tick",   32'(bus.tick),   32'h0);
        check("reset_tick_d", 32'(bus.tick_d), 32'h0);
        check("reset_active", 32'(bus.active), 32'hF);
        RESETn = 1'b1;
        step(30);
        check("dflt_c30_tick", 32'(bus.tick), 32'h0);
        step(1);
        check("dflt_c31_tick",   32'(bus.tick),   32'hF);
        check("dflt_c31_tick_d", 32'(bus.tick_d), 32'h0);
        step(1);
        check("dflt_c32_tick",   32'(bus.tick),   32'h0);
        check("dflt_c32_tick_d", 32'(bus.tick_d), 32'hF);
        step(29);
        check("dflt_c61_tick", 32'(bus.tick), 32'h0);
        step(1);
        check("dflt_c62_tick", 32'(bus.tick), 32'hF);

        // ch1 limit 4: period 5, others keep their phase (ch0 next at cycle 93)
        cfg_write(2'd1, 10'd4, 1'b1, 1'b0);
        check("ch1_wr_tick", 32'(bus.tick[1]), 32'h0);
        watch(15, 1, cnt, first);
        check("ch1_p5_count", 32'(cnt),   32'd3);
        check("ch1_p5_first", 32'(first), 32'd5);
        watch(15, 0, cnt, first);
        check("ch0_unaffected_first", 32'(first), 32'd15);

        // ch2 limit 0: continuous, then disable
        cfg_write(2'd2, 10'd0, 1'b1, 1'b0);
        watch(5, 2, cnt, first);
        check("ch2_l0_count", 32'(cnt),   32'd5);
        check("ch2_l0_first", 32'(first), 32'd1);
        cfg_write(2'd2, 10'd0, 1'b0, 1'b0);
        check("ch2_dis_tick",   32'(bus.tick[2]),   32'h0);
        check("ch2_dis_active", 32'(bus.active[2]), 32'h0);
        watch(10, 2, cnt, first);
        check("ch2_dis_count", 32'(cnt), 32'd0);

        // ch3 one-shot, limit 9
        cfg_write(2'd3, 10'd9, 1'b1, 1'b1);
        check("ch3_arm_active", 32'(bus.active[3]), 32'h1);
        watch(10, 3, cnt, first);
        check("ch3_os_count",  32'(cnt),             32'd1);
        check("ch3_os_first",  32'(first),           32'd10);
        check("ch3_os_active", 32'(bus.active[3]),   32'h0);
        watch(100, 3, cnt, first);
        check("ch3_os_quiet", 32'(cnt), 32'd0);
        cfg_write(2'd3, 10'd9, 1'b1, 1'b1);
        watch(20, 3, cnt, first);
        check("ch3_rearm_count", 32'(cnt),   32'd1);
        check("ch3_rearm_first", 32'(first), 32'd10);

        // ch0/ch1 limit 7 written at different times, then sync aligns them
        cfg_write(2'd0, 10'd7, 1'b1, 1'b0);
        step(3);
        cfg_write(2'd1, 10'd7, 1'b1, 1'b0);
        step(2);
        bus.sync = 1'b1;
        step(1);
        bus.sync = 1'b0;
        both  = 0;
        skew  = 0;
        first = -1;
        for (int i = 1; i <= 24; i++) begin
            step(1);
            if (bus.tick[0] && bus.tick[1]) begin
                both++;
                if (first < 0) first = i;
            end
            if (bus.tick[0] != bus.tick[1]) skew++;
        end
        check("sync_both_count", 32'(both),  32'd3);
        check("sync_first",      32'(first), 32'd8);
        check("sync_skew",       32'(skew),  32'd0);

        // Mid-count reset on ch1 with limit 4
        cfg_write(2'd1, 10'd4, 1'b1, 1'b0);
        step(4);
        check("pre_rst_ch1_tick", 32'(bus.tick[1]), 32'h0);
        step(1);
        check("pre_rst_ch1_tick5", 32'(bus.tick[1]), 32'h1);
        RESETn = 1'b0;
        #1;
        check("midrst_tick",   32'(bus.tick),   32'h0);
        check("midrst_tick_d", 32'(bus.tick_d), 32'h0);
        check("midrst_active", 32'(bus.active), 32'hF);
        step(1);
        RESETn = 1'b1;

        // Out-of-range write on the five-channel instance, watched alongside ch1 recovery
        bus2.cfg_we      = 1'b1;
        bus2.cfg_ch      = 3'd5;
        bus2.cfg_limit   = 10'd2;
        bus2.cfg_en      = 1'b0;
        bus2.cfg_oneshot = 1'b1;
        cnt = 0; first = -1; cnt2 = 0; first2 = -1;
        for (int i = 1; i <= 31; i++) begin
            step(1);
            bus2.cfg_we = 1'b0;
            if (bus.tick[1]) begin
                cnt++;
                if (first < 0) first = i;
            end
            if (bus2.tick != 5'h0) begin
                cnt2++;
                if (first2 < 0) first2 = i;
            end
        end
        check("postrst_ch1_count", 32'(cnt),   32'd1);
        check("postrst_ch1_first", 32'(first), 32'd31);
        check("oor_tick_cycles",   32'(cnt2),  32'd1);
        check("oor_first",         32'(first2), 32'd31);
        check("oor_all_ch",        32'(bus2.tick),   32'h1F);
        check("oor_active",        32'(bus2.active), 32'h1F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
